// File: rtl/waveform_generator.sv
// ----------------------------------------------------------------------------
// waveform_generator
//   N-bit periodic waveform source: triangle, rising sawtooth, falling
//   sawtooth or square, running between programmable bounds lo..hi.
//   The waveform advances only on cycles with ena high. A cfg_we pulse
//   latches a new configuration and restarts the waveform. All arithmetic
//   is done one bit wider than the sample and clamped into [lo,hi], so the
//   output never wraps modulo 2^N.
// ----------------------------------------------------------------------------
module waveform_generator #(
    parameter int N     = 8,
    parameter int CNT_W = N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_mode,
    input  logic [N-1:0]   cfg_step,
    input  logic [N-1:0]   cfg_lo,
    input  logic [N-1:0]   cfg_hi,
    output logic [N-1:0]   out,
    output logic           dir_up,
    output logic           wrap,
    output logic           cfg_err
);

    typedef enum logic [1:0] {
        MODE_TRI    = 2'd0,
        MODE_SAW_UP = 2'd1,
        MODE_SAW_DN = 2'd2,
        MODE_SQUARE = 2'd3
    } mode_t;

    // The square counter is compared against step-1, which always fits in
    // N bits; compare both at a common width wide enough for either.
    localparam int CW = (CNT_W > N + 1) ? CNT_W : N + 1;

    // Latched configuration
    mode_t          mode_q;
    mode_t          mode_d;
    logic [N-1:0]   step_q;
    logic [N-1:0]   step_d;
    logic [N-1:0]   lo_q;
    logic [N-1:0]   lo_d;
    logic [N-1:0]   hi_q;
    logic [N-1:0]   hi_d;

    // Next-state values for the output registers and the square counter
    logic [N-1:0]   out_d;
    logic           dir_up_d;
    logic           wrap_d;
    logic           cfg_err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wide arithmetic helpers
    logic [N:0]     step_eff;
    logic [N:0]     out_ext;
    logic [N:0]     lo_ext;
    logic [N:0]     hi_ext;
    logic [N:0]     up_sum;
    logic [N:0]     up_clamped;
    logic [N:0]     lo_plus_step;
    logic [N:0]     dn_diff;
    logic [N:0]     dn_clamped;
    logic [N:0]     sq_lim;
    logic [CW-1:0]  cnt_wide;
    logic [CW-1:0]  lim_wide;
    logic           sq_terminal;
    logic           sq_level;
    logic           new_err;
    logic           unused_bits;

    // A programmed step of zero behaves exactly like a step of one
    assign step_eff     = (step_q == '0) ? {{N{1'b0}}, 1'b1} : {1'b0, step_q};
    assign out_ext      = {1'b0, out};
    assign lo_ext       = {1'b0, lo_q};
    assign hi_ext       = {1'b0, hi_q};

    // Rising step, clamped at hi: min(out+step, hi)
    assign up_sum       = out_ext + step_eff;
    assign up_clamped   = (up_sum >= hi_ext) ? hi_ext : up_sum;

    // Falling step, clamped at lo: max(out-step, lo). When out <= lo+step
    // the result is lo, so the subtraction below never underflows when used.
    assign lo_plus_step = lo_ext + step_eff;
    assign dn_diff      = out_ext - step_eff;
    assign dn_clamped   = (out_ext <= lo_plus_step) ? lo_ext : dn_diff;

    // Square half-period terminal count is step-1 enabled cycles
    assign sq_lim       = step_eff - {{N{1'b0}}, 1'b1};
    assign cnt_wide     = CW'(cnt_q);
    assign lim_wide     = CW'(sq_lim);
    assign sq_terminal  = (cnt_wide == lim_wide);
    assign sq_level     = (out == hi_q);

    // Configuration legality is judged on the incoming bounds
    assign new_err      = (cfg_lo >= cfg_hi);

    // The top bits of the clamped results are always zero after clamping
    assign unused_bits  = ^{up_clamped[N], dn_clamped[N]};

    // Next-state logic: configuration load has priority over stepping, an
    // illegal configuration freezes the waveform, otherwise step per mode
    always_comb begin
        mode_d    = mode_q;
        step_d    = step_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        out_d     = out;
        dir_up_d  = dir_up;
        wrap_d    = 1'b0;
        cfg_err_d = cfg_err;
        cnt_d     = cnt_q;

        if (cfg_we) begin
            mode_d    = mode_t'(cfg_mode);
            step_d    = cfg_step;
            lo_d      = cfg_lo;
            hi_d      = cfg_hi;
            cfg_err_d = new_err;
            cnt_d     = '0;
            // A falling sawtooth starts from the top; everything else,
            // including any illegal configuration, parks at lo.
            if (!new_err && (mode_t'(cfg_mode) == MODE_SAW_DN)) begin
                out_d = cfg_hi;
            end else begin
                out_d = cfg_lo;
            end
            case (mode_t'(cfg_mode))
                MODE_SAW_DN: dir_up_d = 1'b0;
                MODE_SQUARE: dir_up_d = (cfg_lo == cfg_hi);
                default:     dir_up_d = 1'b1;
            endcase
        end else if (ena && !cfg_err) begin
            case (mode_q)
                MODE_TRI: begin
                    if (dir_up) begin
                        out_d = up_clamped[N-1:0];
                        if (up_clamped == hi_ext) begin
                            dir_up_d = 1'b0;
                        end
                    end else begin
                        out_d = dn_clamped[N-1:0];
                        if (dn_clamped == lo_ext) begin
                            dir_up_d = 1'b1;
                            wrap_d   = 1'b1;
                        end
                    end
                end
                MODE_SAW_UP: begin
                    dir_up_d = 1'b1;
                    if (out == hi_q) begin
                        out_d  = lo_q;
                        wrap_d = 1'b1;
                    end else begin
                        out_d = up_clamped[N-1:0];
                    end
                end
                MODE_SAW_DN: begin
                    dir_up_d = 1'b0;
                    if (out == lo_q) begin
                        out_d  = hi_q;
                        wrap_d = 1'b1;
                    end else begin
                        out_d = dn_clamped[N-1:0];
                    end
                end
                MODE_SQUARE: begin
                    if (sq_terminal) begin
                        cnt_d = '0;
                        if (sq_level) begin
                            out_d    = lo_q;
                            dir_up_d = 1'b0;
                        end else begin
                            out_d    = hi_q;
                            dir_up_d = 1'b1;
                            wrap_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    out_d = out;
                end
            endcase
        end
    end

    // State registers; reset restores the full-scale unit-step triangle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_TRI;
            step_q  <= {{(N-1){1'b0}}, 1'b1};
            lo_q    <= '0;
            hi_q    <= '1;
            out     <= '0;
            dir_up  <= 1'b1;
            wrap    <= 1'b0;
            cfg_err <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            step_q  <= step_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            out     <= out_d;
            dir_up  <= dir_up_d;
            wrap    <= wrap_d;
            cfg_err <= cfg_err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
